// File: rtl/reset_pkg.sv
// reset_pkg: shared types and sizing helpers for the reset sequencers.
//   rst_state_t - sequencer FSM states (SYNC, HOLD, RELEASE, DONE)
//   cnt_width() - width of a counter that must hold max(a, b) without wrapping
package reset_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } rst_state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// reset_sync_chain: release synchroniser for a raw asynchronous reset.
// The chain clears asynchronously while RST is high and shifts in a constant
// 1 on every negedge clk afterwards, so sync_q rises on the STAGES-th edge
// after RST falls.
//   clk    in   clock, flops on negedge
//   RST    in   raw reset, asynchronous assert, active-high
//   sync_q out  synchronised "reset released" flag
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic RST,
    output logic sync_q
);

    logic [STAGES-1:0] chain;

    always_ff @(negedge clk or posedge RST) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_q = chain[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq: sequenced reset generator.
// Synchronises the release of RST, holds every output in reset for
// HOLD_CYCLES edges, then releases rst_n[0], rst_n[1], ... one every STAGGER
// edges. A software request (outside SYNC) drops all outputs and restarts
// the hold. The FSM state is kept in the named signal 'state'.
//   clk        in   clock, all flops on negedge
//   RST        in   raw reset, asynchronous assert, active-high
//   sw_rst_req in   synchronous software reset request, active-high
//   rst_n      out  NUM_CH sequenced resets, active-low, straight from flops
//   rst_done   out  high once every rst_n bit is released
//
// Handshake note: there is no valid/ready traffic here; sw_rst_req is a
// level sampled on each negedge, and every high edge counts as a request.
module reset_seq
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n,
    output logic              rst_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER);
    localparam int CH_W  = $clog2(NUM_CH + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_seq: SYNC_STAGES must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("reset_seq: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_seq: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $error("reset_seq: STAGGER must be >= 1");
    end

    logic             sync_q;
    rst_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  ch;      // index of the next channel to release
    logic             hold_hit;
    logic             stag_hit;
    logic             last_ch;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .RST    (RST),
        .sync_q (sync_q)
    );

    // The edge on which SYNC first sees sync_q is already the first hold edge,
    // so SYNC and HOLD share the same count/compare step.
    assign hold_hit = (cnt == CNT_W'(HOLD_CYCLES - 1));
    assign stag_hit = (cnt == CNT_W'(STAGGER - 1));
    assign last_ch  = (ch == CH_W'(NUM_CH - 1));

    always_ff @(negedge clk or posedge RST) begin
        if (RST) begin
            state    <= SYNC;
            cnt      <= '0;
            ch       <= '0;
            rst_n    <= '0;
            rst_done <= 1'b0;
        end else if (sw_rst_req && (state != SYNC)) begin
            state    <= HOLD;
            cnt      <= '0;
            ch       <= '0;
            rst_n    <= '0;
            rst_done <= 1'b0;
        end else begin
            case (state)
                SYNC, HOLD: begin
                    if ((state == HOLD) || sync_q) begin
                        if (hold_hit) begin
                            rst_n <= NUM_CH'(1);
                            cnt   <= '0;
                            ch    <= CH_W'(1);
                            if (NUM_CH == 1) begin
                                state    <= DONE;
                                rst_done <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            state <= HOLD;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (stag_hit) begin
                        // Shifting a 1 in from the bottom releases channels
                        // strictly in index order and never drops a bit.
                        rst_n <= (rst_n << 1) | NUM_CH'(1);
                        cnt   <= '0;
                        ch    <= ch + 1'b1;
                        if (last_ch) begin
                            state    <= DONE;
                            rst_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    state <= SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: three sequencer configurations driven by a shared RST and
// sw_rst_req. The reference model only tracks the edge number since RST fell
// and, per configuration, the edge at which channel 0 is due; channel i is
// then due STAGGER*i edges later.
module tb_reset_seq;

    localparam int ND = 3;
    // config 0: defaults; config 1: single channel, minimal hold;
    // config 2: four channels released on consecutive edges
    int ss [ND] = '{2, 3, 2};
    int nc [ND] = '{3, 1, 4};
    int hc [ND] = '{16, 1, 5};
    int st [ND] = '{4, 4, 1};

    logic       clk = 1'b1;
    logic       rst_raw = 1'b1;
    logic       sw = 1'b0;
    logic [2:0] rn0;
    logic [0:0] rn1;
    logic [3:0] rn2;
    logic       dn0, dn1, dn2;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;     // negedge count since RST fell
    int base [ND];     // edge at which channel 0 is due

    always #5 clk = ~clk;

    reset_seq #(.SYNC_STAGES(2), .NUM_CH(3), .HOLD_CYCLES(16), .STAGGER(4)) u_d0 (
        .clk(clk), .RST(rst_raw), .sw_rst_req(sw), .rst_n(rn0), .rst_done(dn0));
    reset_seq #(.SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER(4)) u_d1 (
        .clk(clk), .RST(rst_raw), .sw_rst_req(sw), .rst_n(rn1), .rst_done(dn1));
    reset_seq #(.SYNC_STAGES(2), .NUM_CH(4), .HOLD_CYCLES(5), .STAGGER(1)) u_d2 (
        .clk(clk), .RST(rst_raw), .sw_rst_req(sw), .rst_n(rn2), .rst_done(dn2));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rn(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < nc[d]; i++)
            if (k >= base[d] + i * st[d]) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] model_done(input int d);
        return {31'b0, (k >= base[d] + (nc[d] - 1) * st[d])};
    endfunction

    function automatic logic [31:0] obs_rn(input int d);
        case (d)
            0:       return {29'b0, rn0};
            1:       return {31'b0, rn1};
            default: return {28'b0, rn2};
        endcase
    endfunction

    function automatic logic [31:0] obs_done(input int d);
        case (d)
            0:       return {31'b0, dn0};
            1:       return {31'b0, dn1};
            default: return {31'b0, dn2};
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int d = 0; d < ND; d++) begin
            check_val($sformatf("%s_rst_n_d%0d", tag, d), obs_rn(d), model_rn(d));
            check_val($sformatf("%s_done_d%0d", tag, d), obs_done(d), model_done(d));
        end
    endtask

    // Called just after a posedge; one negedge, then compare after the next posedge.
    task automatic step(input logic req);
        sw = req;
        @(negedge clk);
        k++;
        for (int d = 0; d < ND; d++)
            if (req && (k >= ss[d] + 2)) base[d] = k + hc[d];
        @(posedge clk);
        #1;
        check_all("seq");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // RST rises between clock edges; outputs must drop before any edge.
    task automatic do_reset(input int cycles);
        sw = 1'b0;
        #2;
        rst_raw = 1'b1;
        k = 0;
        for (int d = 0; d < ND; d++) base[d] = ss[d] + hc[d];
        #1;
        check_all("async");
        repeat (cycles) @(posedge clk);
        #1;
        check_all("held");
        rst_raw = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) base[d] = ss[d] + hc[d];
        @(posedge clk);
        #1;
        check_all("por");
        repeat (4) @(posedge clk);
        #1;
        rst_raw = 1'b0;
        // power-on sequence through DONE
        run(30);
        // software pulse in DONE
        step(1'b1);
        run(30);
        // two requests during HOLD: timing restarts from the second
        step(1'b1);
        run(4);
        step(1'b1);
        run(30);
        // RST mid-release, then full restart
        do_reset(2);
        run(20);
        do_reset(1);
        // requests during SYNC are ignored
        step(1'b1);
        step(1'b1);
        run(30);
        // async assert in DONE
        do_reset(3);
        run(30);
        // randomized requests and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset($urandom_range(1, 4));
            end else if ((k + 1 == 3) || (k + 1 == 4)) begin
                step(1'b0);
            end else begin
                step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            end
        end
        run(30);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
